// File: rtl/cim_pkg.sv
// Shared definitions for the CIM row sequencer: command/state encodings, array
// geometry and the row-selection helper.
package cim_pkg;

    localparam int ROWS  = 4;
    localparam int ACC_W = 3;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_CAM   = 2'd1,
        OP_MAC   = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] row;
    } row_sel_t;

    // Lowest set bit of mask at or above start; rows are always walked upward.
    function automatic row_sel_t first_row_from(input logic [ROWS-1:0] mask,
                                                input logic [2:0]      start);
        row_sel_t sel;
        sel.found = 1'b0;
        sel.row   = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) begin
                sel.found = 1'b1;
                sel.row   = 2'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cim_row_sequencer_if.sv
// Command/response handshake bundle between a command source and the sequencer.
interface cim_row_sequencer_if #(
    parameter int COLS = 4
) ();

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [1:0]                    cmd_op;
    logic [1:0]                    cmd_addr;
    logic [3:0]                    cmd_data;
    logic                          cmd_inv;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [COLS*cim_pkg::ACC_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_inv, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_inv, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/cim_col_accum.sv
// Per-column MAC counters: cleared per command, incremented by one sense bit
// per visited row. sum_bus is the running total including the current bits.
module cim_col_accum
    import cim_pkg::*;
#(
    parameter int COLS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  add_en,
    input  logic [COLS-1:0]       add_bits,
    output logic [COLS*ACC_W-1:0] sum_bus
);

    logic [ACC_W-1:0] acc_q [COLS];
    logic [ACC_W-1:0] acc_d [COLS];
    logic [ACC_W-1:0] sum_s [COLS];

    // Per-column sum and next counter value.
    always_comb begin
        sum_bus = '0;
        for (int c = 0; c < COLS; c++) begin
            sum_s[c] = acc_q[c] + ACC_W'(add_bits[c]);
            sum_bus[c*ACC_W +: ACC_W] = sum_s[c];
            if (clr) begin
                acc_d[c] = '0;
            end else if (add_en) begin
                acc_d[c] = sum_s[c];
            end else begin
                acc_d[c] = acc_q[c];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < COLS; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

endmodule

// File: rtl/cim_row_sequencer.sv
// Sequences WRITE / CAM / MAC commands onto the CIM row decoder pins, waits for
// the array to settle, samples the sense amps and returns one response each.
module cim_row_sequencer
    import cim_pkg::*;
#(
    parameter int COLS      = 4,
    parameter int SETTLE    = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    cim_row_sequencer_if.slave bus,
    input  logic [COLS-1:0]    sa_out,
    output logic               cs,
    output logic               MAC_en,
    output logic               read_bar,
    output logic               w_en,
    output logic [1:0]         addr,
    output logic [3:0]         data,
    output logic               col_wr_en
);

    localparam int RSP_W    = COLS * ACC_W;
    localparam int MAX_HOLD = (SETTLE > WR_CYCLES) ? SETTLE : WR_CYCLES;
    localparam int CNT_W    = $clog2(MAX_HOLD + 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [1:0]         cmd_addr_q, cmd_addr_d;
    logic [3:0]         cmd_data_q, cmd_data_d;
    logic               inv_q, inv_d;
    logic [1:0]         row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0]   rsp_data_q, rsp_data_d;
    logic               cs_q, cs_d;
    logic               mac_en_q, mac_en_d;
    logic               read_bar_q, read_bar_d;
    logic               w_en_q, w_en_d;
    logic [1:0]         addr_q, addr_d;
    logic [3:0]         data_q, data_d;
    logic               col_wr_en_q, col_wr_en_d;

    logic               acc_clr_s;
    logic               acc_add_s;
    logic [RSP_W-1:0]   acc_sum_s;
    logic               drive_s;
    row_sel_t           first_sel_s;
    row_sel_t           next_sel_s;

    cim_col_accum #(
        .COLS (COLS)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr_s),
        .add_en   (acc_add_s),
        .add_bits (sa_out),
        .sum_bus  (acc_sum_s)
    );

    // Command FSM: acceptance, issue/settle timing, row walk and response capture.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        inv_d       = inv_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        acc_clr_s   = 1'b0;
        acc_add_s   = 1'b0;
        first_sel_s = first_row_from(bus.cmd_data, 3'd0);
        next_sel_s  = first_row_from(cmd_data_q, {1'b0, row_q} + 3'd1);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d       = op_e'(bus.cmd_op);
                    cmd_addr_d = bus.cmd_addr;
                    cmd_data_d = bus.cmd_data;
                    inv_d      = bus.cmd_inv;
                    acc_clr_s  = 1'b1;
                    rsp_data_d = '0;
                    case (op_e'(bus.cmd_op))
                        OP_WRITE: state_d = ISSUE;
                        OP_CAM:   state_d = ISSUE;
                        OP_MAC: begin
                            if (first_sel_s.found) begin
                                state_d = ISSUE;
                                row_d   = first_sel_s.row;
                            end else begin
                                state_d = RESP;
                            end
                        end
                        default:  state_d = RESP;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                if (op_q == OP_WRITE) begin
                    cnt_d = CNT_W'(WR_CYCLES - 1);
                end else begin
                    cnt_d = CNT_W'(SETTLE - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    case (op_q)
                        OP_WRITE: state_d = RESP;
                        OP_CAM: begin
                            rsp_data_d = RSP_W'(sa_out);
                            state_d    = RESP;
                        end
                        OP_MAC: begin
                            acc_add_s = 1'b1;
                            // Go straight back to ISSUE so MAC_en never drops between rows.
                            if (next_sel_s.found) begin
                                row_d   = next_sel_s.row;
                                state_d = ISSUE;
                            end else begin
                                rsp_data_d = acc_sum_s;
                                state_d    = RESP;
                            end
                        end
                        default:  state_d = RESP;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state so pins are registered.
    always_comb begin
        drive_s     = (state_d == ISSUE) || (state_d == WAIT);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        cs_d        = drive_s;
        mac_en_d    = 1'b0;
        read_bar_d  = 1'b0;
        w_en_d      = 1'b0;
        col_wr_en_d = 1'b0;
        addr_d      = 2'd0;
        data_d      = 4'd0;
        if (drive_s) begin
            case (op_d)
                OP_WRITE: begin
                    w_en_d      = 1'b1;
                    col_wr_en_d = 1'b1;
                    addr_d      = cmd_addr_d;
                end
                OP_CAM: begin
                    data_d = cmd_data_d;
                end
                OP_MAC: begin
                    mac_en_d   = 1'b1;
                    read_bar_d = inv_d;
                    addr_d     = row_d;
                end
                default: begin
                    cs_d = 1'b0;
                end
            endcase
        end else begin
            cs_d = 1'b0;
        end
    end

    // State, command latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            cmd_addr_q  <= 2'd0;
            cmd_data_q  <= 4'd0;
            inv_q       <= 1'b0;
            row_q       <= 2'd0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cs_q        <= 1'b0;
            mac_en_q    <= 1'b0;
            read_bar_q  <= 1'b0;
            w_en_q      <= 1'b0;
            addr_q      <= 2'd0;
            data_q      <= 4'd0;
            col_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            inv_q       <= inv_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cs_q        <= cs_d;
            mac_en_q    <= mac_en_d;
            read_bar_q  <= read_bar_d;
            w_en_q      <= w_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            col_wr_en_q <= col_wr_en_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign cs            = cs_q;
    assign MAC_en        = mac_en_q;
    assign read_bar      = read_bar_q;
    assign w_en          = w_en_q;
    assign addr          = addr_q;
    assign data          = data_q;
    assign col_wr_en     = col_wr_en_q;

endmodule
